jtframe_rst_seq: RTL and testbench



---
 rtl/jtframe_rst_pkg.sv | 17 +
 rtl/jtframe_sync2.sv | 26 ++
 rtl/jtframe_rst_seq.sv | 164 ++++++++++++++++
 tb/tb_jtframe_rst_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_rst_pkg.sv
// Shared definitions for the reset sequencer.
// State encoding constants are exported so that debug and OSD readers can
// decode the st output of jtframe_rst_seq without duplicating the values.
package jtframe_rst_pkg;

  // Sequencer states, as seen on the st debug output
  localparam logic [1:0] ST_WAIT = 2'd0;  // waiting for synchronised lock
  localparam logic [1:0] ST_FILT = 2'd1;  // lock filter running
  localparam logic [1:0] ST_SDR  = 2'd2;  // SDRAM out of reset, waiting for init
  localparam logic [1:0] ST_RUN  = 2'd3;  // core hold / core running

  // Counter width able to hold the larger of the two terminal counts
  function automatic int unsigned rst_cnt_w(input int unsigned a, input int unsigned b);
    return $clog2(a > b ? a : b) + 1;
  endfunction

endpackage

// File: rtl/jtframe_sync2.sv
// Generic two flip-flop synchroniser for a single level signal.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both stages to 0
//   d     - asynchronous input level
//   q     - input level synchronised to clk (two cycles of latency)
module jtframe_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= 2'b00;
    end else begin
      ff_q <= {ff_q[0], d};
    end
  end

  assign q = ff_q[1];

endmodule

// File: rtl/jtframe_rst_seq.sv
// Reset sequencer for one game-clock domain (clk_rom by default).
// Brings up the SDRAM controller first, once the PLL lock has been stable for
// LOCK_CNT cycles, and then the game core HOLD_CNT cycles after the SDRAM
// reports ready. A soft reset request only re-holds the core. Losing lock after
// the filter has passed restarts everything and sets a sticky lock_lost flag.
// Ports:
//   clk         - sequencer clock
//   rst_n       - asynchronous active-low reset
//   pll_locked  - raw PLL lock, asynchronous
//   soft_rst    - soft game reset request, asynchronous level
//   sdram_ready - SDRAM initialisation done, synchronous to clk
//   lost_clr    - clears lock_lost, synchronous to clk
//   sdram_rst   - active-high SDRAM controller reset (registered)
//   core_rst    - active-high game core reset (registered)
//   lock_lost   - sticky: lock dropped after the filter had passed
//   st          - current state for debug (see jtframe_rst_pkg)
module jtframe_rst_seq
  import jtframe_rst_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 1024,  // min 2
  parameter int unsigned HOLD_CNT = 256    // min 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_rst,
  input  logic       sdram_ready,
  input  logic       lost_clr,
  output logic       sdram_rst,
  output logic       core_rst,
  output logic       lock_lost,
  output logic [1:0] st
);

  localparam int unsigned CW = rst_cnt_w(LOCK_CNT, HOLD_CNT);

  localparam logic [CW-1:0] LOCK_TERM = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] HOLD_TERM = CW'(HOLD_CNT - 1);

  logic lk_s;
  logic sr_s;

  jtframe_sync2 u_sync_lock (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pll_locked),
    .q    (lk_s)
  );

  jtframe_sync2 u_sync_soft (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (soft_rst),
    .q    (sr_s)
  );

  logic [1:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_q, hold_d;
  logic          lost_q, lost_d;
  logic          sdram_rst_q, sdram_rst_d;
  logic          core_rst_q, core_rst_d;

  logic [CW-1:0] cnt_inc;
  logic          lock_drop;

  // The counter never wraps: every path that would step past a terminal value
  // either changes state or stops counting, so a plain increment is enough.
  assign cnt_inc   = cnt_q + CW'(1);
  assign lock_drop = !lk_s && ((st_q == ST_SDR) || (st_q == ST_RUN));

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    // A lock drop below sets the flag again, so set wins over clear
    lost_d = lost_q & ~lost_clr;

    if (lock_drop) begin
      st_d   = ST_WAIT;
      cnt_d  = '0;
      hold_d = 1'b0;
      lost_d = 1'b1;
    end else begin
      unique case (st_q)
        ST_WAIT: begin
          if (lk_s) begin
            st_d  = ST_FILT;
            cnt_d = '0;
          end
        end

        ST_FILT: begin
          if (!lk_s) begin
            // Lock never qualified, so this is not a lock loss
            st_d  = ST_WAIT;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
            // The WAIT cycle that saw lk_s already counts as one lock cycle
            if (cnt_inc == LOCK_TERM) begin
              st_d = ST_SDR;
            end
          end
        end

        ST_SDR: begin
          if (sdram_ready) begin
            st_d   = ST_RUN;
            hold_d = 1'b1;
            cnt_d  = '0;
          end
        end

        ST_RUN: begin
          if (hold_q) begin
            if (sr_s) begin
              cnt_d = '0;
            end else if (cnt_q == HOLD_TERM) begin
              hold_d = 1'b0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (sr_s) begin
            hold_d = 1'b1;
            cnt_d  = '0;
          end
        end

        default: begin
          st_d = ST_WAIT;
        end
      endcase
    end

    // Resets are derived from the next state so they change on the same edge
    sdram_rst_d = (st_d == ST_WAIT) || (st_d == ST_FILT);
    core_rst_d  = !((st_d == ST_RUN) && !hold_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= ST_WAIT;
      cnt_q       <= '0;
      hold_q      <= 1'b0;
      lost_q      <= 1'b0;
      sdram_rst_q <= 1'b1;
      core_rst_q  <= 1'b1;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      lost_q      <= lost_d;
      sdram_rst_q <= sdram_rst_d;
      core_rst_q  <= core_rst_d;
    end
  end

  assign sdram_rst = sdram_rst_q;
  assign core_rst  = core_rst_q;
  assign lock_lost = lost_q;
  assign st        = st_q;

endmodule

// File: tb/tb_jtframe_rst_seq.sv
// Self-checking bench for jtframe_rst_seq with LOCK_CNT=16, HOLD_CNT=8.
// Expected output words {sdram_rst, core_rst, lock_lost, st} are queued with
// the edge number (counted from rst_n release) at which they must be visible.
module tb_jtframe_rst_seq;

  localparam int unsigned LOCK_CNT = 16;
  localparam int unsigned HOLD_CNT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_rst = 1'b0;
  logic       sdram_ready = 1'b0;
  logic       lost_clr = 1'b0;
  logic       sdram_rst;
  logic       core_rst;
  logic       lock_lost;
  logic [1:0] st;
  logic [4:0] outs;

  assign outs = {sdram_rst, core_rst, lock_lost, st};

  jtframe_rst_seq #(
    .LOCK_CNT(LOCK_CNT),
    .HOLD_CNT(HOLD_CNT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .soft_rst   (soft_rst),
    .sdram_ready(sdram_ready),
    .lost_clr   (lost_clr),
    .sdram_rst  (sdram_rst),
    .core_rst   (core_rst),
    .lock_lost  (lock_lost),
    .st         (st)
  );

  always #5 clk = ~clk;

  // Edge number since the last rst_n release
  int cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    string      tag;
    int         at;
    logic [4:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_at(input string tag, input int at, input logic [4:0] val);
    exp_t e;
    e.tag = tag;
    e.at  = at;
    e.val = val;
    sb.push_back(e);
  endtask

  // Return just after edge n has been applied
  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (sb.size() > 0 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    #1 chk(tag, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard consumer: outputs are sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        mon_e = sb.pop_front();
        if (mon_e.at == cyc) chk(mon_e.tag, {27'd0, outs}, {27'd0, mon_e.val});
        else                 chk({mon_e.tag, "_late"}, 32'(cyc), 32'(mon_e.at));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got t=%0t expected end of test", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values, before any clock edge
    pll_locked = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk("rst_vals", {27'd0, outs}, 32'h18);

    // 1: clean bring-up
    expect_at("s1_wait1", 1, 5'b11000);
    expect_at("s1_wait2", 2, 5'b11000);
    expect_at("s1_filt", 3, 5'b11001);
    expect_at("s1_filt_end", 17, 5'b11001);
    expect_at("s1_sdr", 18, 5'b01010);
    expect_at("s1_sdr_wait", 25, 5'b01010);
    expect_at("s1_hold", 26, 5'b01011);
    expect_at("s1_hold_end", 33, 5'b01011);
    expect_at("s1_run", 34, 5'b00011);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_edge(25);
    sdram_ready = 1'b1;
    wait_edge(36);
    drain("s1_drain");

    // 2: lock glitch while filtering (3 cycles low at filter count 10)
    sdram_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    expect_at("s2_filt10", 13, 5'b11001);
    expect_at("s2_filt_late", 15, 5'b11001);
    expect_at("s2_back_wait", 16, 5'b11000);
    expect_at("s2_wait_hold", 18, 5'b11000);
    expect_at("s2_refilt", 19, 5'b11001);
    expect_at("s2_refilt_end", 33, 5'b11001);
    expect_at("s2_sdr", 34, 5'b01010);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_edge(13);
    pll_locked = 1'b0;
    wait_edge(16);
    pll_locked = 1'b1;
    wait_edge(34);

    // 3: lock loss in RUN, clear flag, relock with sdram_ready already high
    expect_at("s3_hold", 35, 5'b01011);
    expect_at("s3_hold_end", 42, 5'b01011);
    expect_at("s3_run", 43, 5'b00011);
    expect_at("s3_pre_loss", 47, 5'b00011);
    expect_at("s3_loss", 48, 5'b11100);
    expect_at("s3_lost_held", 50, 5'b11100);
    expect_at("s3_lost_clr", 51, 5'b11000);
    expect_at("s3_relock_wait", 54, 5'b11000);
    expect_at("s3_relock_filt", 55, 5'b11001);
    expect_at("s3_relock_filt_end", 69, 5'b11001);
    expect_at("s3_relock_sdr", 70, 5'b01010);
    expect_at("s3_relock_hold", 71, 5'b01011);
    expect_at("s3_relock_hold_end", 78, 5'b01011);
    expect_at("s3_relock_run", 79, 5'b00011);
    sdram_ready = 1'b1;
    wait_edge(45);
    pll_locked = 1'b0;
    wait_edge(50);
    lost_clr = 1'b1;
    wait_edge(51);
    lost_clr = 1'b0;
    wait_edge(52);
    pll_locked = 1'b1;
    wait_edge(80);
    drain("s3_drain");

    // 4: soft reset for 20 cycles while running
    expect_at("s4_pre", 87, 5'b00011);
    expect_at("s4_core_on", 88, 5'b01011);
    expect_at("s4_held", 100, 5'b01011);
    expect_at("s4_hold_end", 114, 5'b01011);
    expect_at("s4_core_off", 115, 5'b00011);
    wait_edge(85);
    soft_rst = 1'b1;
    wait_edge(105);
    soft_rst = 1'b0;
    wait_edge(116);
    drain("s4_drain");

    // 5: lost_clr with lock loss, then soft_rst with lock loss
    expect_at("s5_pre", 122, 5'b00011);
    expect_at("s5_clr_vs_set", 123, 5'b11100);
    expect_at("s5_refilt", 128, 5'b11101);
    expect_at("s5_sdr", 143, 5'b01110);
    expect_at("s5_hold", 144, 5'b01111);
    expect_at("s5_run", 152, 5'b00111);
    expect_at("s5_pre2", 157, 5'b00111);
    expect_at("s5_loss_soft", 158, 5'b11100);
    wait_edge(120);
    pll_locked = 1'b0;
    wait_edge(122);
    lost_clr = 1'b1;
    wait_edge(123);
    lost_clr = 1'b0;
    wait_edge(125);
    pll_locked = 1'b1;
    wait_edge(155);
    pll_locked = 1'b0;
    soft_rst = 1'b1;
    wait_edge(158);
    soft_rst = 1'b0;

    // 6: asynchronous reset while in SDR, then restart
    expect_at("s6_filt", 163, 5'b11101);
    expect_at("s6_sdr", 178, 5'b01110);
    expect_at("s6_sdr_hold", 180, 5'b01110);
    wait_edge(160);
    sdram_ready = 1'b0;
    pll_locked = 1'b1;
    wait_edge(180);
    drain("s6_drain");
    #2 rst_n = 1'b0;
    #1 chk("s6_async_rst", {27'd0, outs}, 32'h18);
    expect_at("s6_restart_wait", 2, 5'b11000);
    expect_at("s6_restart_filt", 3, 5'b11001);
    expect_at("s6_restart_filt_end", 17, 5'b11001);
    expect_at("s6_restart_sdr", 18, 5'b01010);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_edge(20);
    drain("s6_restart_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
